drra_exec_ctrl: RTL and testbench

Execution controller for the DRRA fabric behind the APB slave interface. It launches a configured set of DRRA rows with a single-cycle `call` pulse, then collects each row's `ret` and measures run time in cycles. An optional watchdog ends the run if it exceeds a limit. On completion it reports status through registered CSR-facing outputs and a level interrupt. The APB slave CSR logic drives its configuration and command inputs and reads back its status; its `call` output replaces direct CSR-driven `call` generation.

---
 rtl/drra_exec_ctrl_if.sv | 36 +++
 rtl/drra_exec_ctrl.sv | 111 +++++++++++
 tb/tb_drra_exec_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/drra_exec_ctrl_if.sv
// CSR/DRRA-facing signal bundle for drra_exec_ctrl: configuration, commands,
// per-row call/ret, and status readback. dbg_state mirrors the controller FSM.
interface drra_exec_ctrl_if #(
  parameter int ROWS  = 4,
  parameter int CNT_W = 32
);
  logic [ROWS-1:0]  cfg_row_mask;
  logic [CNT_W-1:0] cfg_timeout;
  logic             start;
  logic             abort;
  logic             irq_clr;
  logic [ROWS-1:0]  ret;
  logic [ROWS-1:0]  call;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic             aborted;
  logic [ROWS-1:0]  ret_seen;
  logic [CNT_W-1:0] cycle_count;
  logic             irq;
  logic [1:0]       dbg_state;

  // Commands are single-cycle pulses sampled on the rising clock edge; there is
  // no valid/ready backpressure: a pulse not accepted in its cycle is dropped.
  modport master (
    output cfg_row_mask, cfg_timeout, start, abort, irq_clr, ret,
    input  call, busy, done, timeout_err, aborted, ret_seen, cycle_count, irq,
           dbg_state
  );

  modport slave (
    input  cfg_row_mask, cfg_timeout, start, abort, irq_clr, ret,
    output call, busy, done, timeout_err, aborted, ret_seen, cycle_count, irq,
           dbg_state
  );
endinterface

// File: rtl/drra_exec_ctrl.sv
// DRRA execution controller: launches masked rows, collects ret, counts WAIT cycles.
// Optional watchdog enabled by defining DRRA_EXEC_CTRL_TIMEOUT_EN.
module drra_exec_ctrl #(
  parameter int ROWS  = 4,
  parameter int CNT_W = 32
) (
  input logic             clk,
  input logic             rst,
  drra_exec_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALL, WAIT, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [ROWS-1:0]  mask_q;
  logic [ROWS-1:0]  seen_q;
  logic [ROWS-1:0]  seen_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             abt_q;
  logic             irq_q;
  logic             start_ok;
  logic             run_abort;
  logic             complete;
  logic             tmo_hit;
  logic             tmo_err;

`ifdef DRRA_EXEC_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_lim_q;
  logic             tmo_q;

  assign tmo_hit = (tmo_lim_q != '0) && (cnt_inc == tmo_lim_q);
  assign tmo_err = tmo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_lim_q <= '0;
      tmo_q     <= 1'b0;
    end else if (start_ok) begin
      tmo_lim_q <= bus.cfg_timeout;
      tmo_q     <= 1'b0;
    end else if (state == WAIT && !run_abort && !complete && tmo_hit) begin
      tmo_q <= 1'b1;
    end
  end
`else
  logic cfg_timeout_unused;

  assign cfg_timeout_unused = ^bus.cfg_timeout;
  assign tmo_hit            = 1'b0;
  assign tmo_err            = 1'b0;
`endif

  always_comb begin
    start_ok  = (state == IDLE) && bus.start && (bus.cfg_row_mask != '0);
    run_abort = bus.abort && (state == CALL || state == WAIT);
    seen_nxt  = seen_q | (bus.ret & mask_q);
    // Counter saturates rather than wrapping so a stuck run never looks short.
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
    complete  = (seen_nxt == mask_q);
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = CALL;
      CALL: state_nxt = run_abort ? IDLE : WAIT;
      WAIT: begin
        if (run_abort)                 state_nxt = IDLE;
        else if (complete || tmo_hit)  state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mask_q <= '0;
      seen_q <= '0;
      cnt_q  <= '0;
      abt_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        mask_q <= bus.cfg_row_mask;
        seen_q <= '0;
        cnt_q  <= '0;
        abt_q  <= 1'b0;
      end
      if (state == WAIT && !run_abort) begin
        seen_q <= seen_nxt;
        cnt_q  <= cnt_inc;
      end
      if (run_abort) abt_q <= 1'b1;
      // Setting on DONE entry and during DONE lets a coincident clear lose.
      if (state == DONE || (state == WAIT && state_nxt == DONE)) irq_q <= 1'b1;
      else if (bus.irq_clr)                                       irq_q <= 1'b0;
    end
  end

  assign bus.call        = (state == CALL) ? mask_q : '0;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.timeout_err = tmo_err;
  assign bus.aborted     = abt_q;
  assign bus.ret_seen    = seen_q;
  assign bus.cycle_count = cnt_q;
  assign bus.irq         = irq_q;
  assign bus.dbg_state   = state;
endmodule

// File: tb/tb_drra_exec_ctrl.sv
// Directed bench for drra_exec_ctrl; timeout scenario adapts to DRRA_EXEC_CTRL_TIMEOUT_EN.
module tb_drra_exec_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  drra_exec_ctrl_if #(.ROWS(4), .CNT_W(32)) bus ();

  drra_exec_ctrl #(.ROWS(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.cfg_row_mask = '0;
    bus.cfg_timeout  = '0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.irq_clr      = 1'b0;
    bus.ret          = '0;

    // reset
    rst = 1'b1;
    tick(2);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_call", 64'(bus.call), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_irq", 64'(bus.irq), 64'd0);
    chk("rst_seen", 64'(bus.ret_seen), 64'd0);
    chk("rst_cnt", 64'(bus.cycle_count), 64'd0);
    chk("rst_terr", 64'(bus.timeout_err), 64'd0);
    chk("rst_abt", 64'(bus.aborted), 64'd0);
    chk("rst_state", 64'(bus.dbg_state), 64'd0);
    rst = 1'b0;
    tick();

    // run 1: mask 0101, ret[0] in WAIT cycle 3, ret[2] in WAIT cycle 7
    bus.cfg_row_mask = 4'b0101;
    bus.cfg_timeout  = 32'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("r1_call", 64'(bus.call), 64'h5);
    chk("r1_busy", 64'(bus.busy), 64'd1);
    tick();
    chk("r1_call_drop", 64'(bus.call), 64'd0);
    tick(2);
    bus.ret = 4'b0001;
    tick();
    bus.ret = 4'b0000;
    chk("r1_seen3", 64'(bus.ret_seen), 64'h1);
    chk("r1_cnt3", 64'(bus.cycle_count), 64'd3);
    chk("r1_nodone", 64'(bus.done), 64'd0);
    tick(3);
    bus.ret = 4'b0100;
    tick();
    bus.ret = 4'b0000;
    chk("r1_done", 64'(bus.done), 64'd1);
    chk("r1_cnt", 64'(bus.cycle_count), 64'd7);
    chk("r1_seen", 64'(bus.ret_seen), 64'h5);
    chk("r1_irq", 64'(bus.irq), 64'd1);
    chk("r1_terr", 64'(bus.timeout_err), 64'd0);
    tick();
    chk("r1_done_pulse", 64'(bus.done), 64'd0);
    chk("r1_idle", 64'(bus.busy), 64'd0);
    chk("r1_irq_hold", 64'(bus.irq), 64'd1);
    chk("r1_cnt_hold", 64'(bus.cycle_count), 64'd7);
    bus.irq_clr = 1'b1;
    tick();
    bus.irq_clr = 1'b0;
    chk("r1_irq_clr", 64'(bus.irq), 64'd0);

    // run 2: timeout 5, mask 0011, only ret[0]
    bus.cfg_row_mask = 4'b0011;
    bus.cfg_timeout  = 32'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.ret = 4'b0001;
    tick();
    bus.ret = 4'b0000;
    tick(4);
`ifdef DRRA_EXEC_CTRL_TIMEOUT_EN
    chk("r2_done", 64'(bus.done), 64'd1);
    chk("r2_terr", 64'(bus.timeout_err), 64'd1);
    chk("r2_cnt", 64'(bus.cycle_count), 64'd5);
    chk("r2_seen", 64'(bus.ret_seen), 64'h1);
    tick();
    chk("r2_idle", 64'(bus.busy), 64'd0);
    chk("r2_terr_sticky", 64'(bus.timeout_err), 64'd1);
    bus.irq_clr = 1'b1;
    tick();
    bus.irq_clr = 1'b0;
`else
    chk("r2_nodone", 64'(bus.done), 64'd0);
    chk("r2_busy", 64'(bus.busy), 64'd1);
    chk("r2_terr", 64'(bus.timeout_err), 64'd0);
    chk("r2_cnt", 64'(bus.cycle_count), 64'd5);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("r2_abort_idle", 64'(bus.busy), 64'd0);
    chk("r2_aborted", 64'(bus.aborted), 64'd1);
`endif
    chk("r2_irq_low", 64'(bus.irq), 64'd0);

    // run 3: timeout 4, last ret in WAIT cycle 4, start while busy ignored
    bus.cfg_row_mask = 4'b0011;
    bus.cfg_timeout  = 32'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("r3_terr_clr", 64'(bus.timeout_err), 64'd0);
    chk("r3_abt_clr", 64'(bus.aborted), 64'd0);
    tick();
    bus.ret = 4'b0001;
    tick();
    bus.ret = 4'b0000;
    bus.cfg_row_mask = 4'b1100;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("r3_busy_start_call", 64'(bus.call), 64'd0);
    chk("r3_busy_start_busy", 64'(bus.busy), 64'd1);
    chk("r3_cnt2", 64'(bus.cycle_count), 64'd2);
    tick();
    bus.ret = 4'b0010;
    tick();
    bus.ret = 4'b0000;
    chk("r3_done", 64'(bus.done), 64'd1);
    chk("r3_terr", 64'(bus.timeout_err), 64'd0);
    chk("r3_cnt", 64'(bus.cycle_count), 64'd4);
    chk("r3_seen", 64'(bus.ret_seen), 64'h3);
    bus.irq_clr = 1'b1;
    tick();
    bus.irq_clr = 1'b0;
    chk("r3_irq_set_wins", 64'(bus.irq), 64'd1);
    chk("r3_done_pulse", 64'(bus.done), 64'd0);
    bus.irq_clr = 1'b1;
    tick();
    bus.irq_clr = 1'b0;
    chk("r3_irq_clr", 64'(bus.irq), 64'd0);

    // start with mask 0 ignored
    bus.cfg_row_mask = 4'b0000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("m0_busy", 64'(bus.busy), 64'd0);
    chk("m0_call", 64'(bus.call), 64'd0);
    chk("m0_cnt", 64'(bus.cycle_count), 64'd4);
    chk("m0_seen", 64'(bus.ret_seen), 64'h3);

    // run 4: abort in WAIT cycle 2
    bus.cfg_row_mask = 4'b1111;
    bus.cfg_timeout  = 32'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(2);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("r4_idle", 64'(bus.busy), 64'd0);
    chk("r4_aborted", 64'(bus.aborted), 64'd1);
    chk("r4_nodone", 64'(bus.done), 64'd0);
    chk("r4_irq", 64'(bus.irq), 64'd0);
    chk("r4_call", 64'(bus.call), 64'd0);
    tick();
    chk("r4_nodone2", 64'(bus.done), 64'd0);
    chk("r4_aborted_hold", 64'(bus.aborted), 64'd1);

    // run 5: mask 0001, ret[3] outside mask ignored
    bus.cfg_row_mask = 4'b0001;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("r5_abt_clr", 64'(bus.aborted), 64'd0);
    chk("r5_call", 64'(bus.call), 64'h1);
    tick();
    bus.ret = 4'b1000;
    tick();
    bus.ret = 4'b0000;
    chk("r5_seen_masked", 64'(bus.ret_seen), 64'h0);
    chk("r5_busy", 64'(bus.busy), 64'd1);
    chk("r5_cnt1", 64'(bus.cycle_count), 64'd1);
    bus.ret = 4'b1001;
    tick();
    bus.ret = 4'b0000;
    chk("r5_seen", 64'(bus.ret_seen), 64'h1);
    chk("r5_done", 64'(bus.done), 64'd1);
    tick();

    // run 6: rst mid-WAIT
    bus.cfg_row_mask = 4'b0011;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.ret = 4'b0001;
    tick();
    bus.ret = 4'b0000;
    tick();
    chk("r6_busy", 64'(bus.busy), 64'd1);
    chk("r6_cnt", 64'(bus.cycle_count), 64'd2);
    chk("r6_irq_pre", 64'(bus.irq), 64'd1);
    rst = 1'b1;
    tick();
    chk("r6_rst_busy", 64'(bus.busy), 64'd0);
    chk("r6_rst_call", 64'(bus.call), 64'd0);
    chk("r6_rst_done", 64'(bus.done), 64'd0);
    chk("r6_rst_irq", 64'(bus.irq), 64'd0);
    chk("r6_rst_seen", 64'(bus.ret_seen), 64'd0);
    chk("r6_rst_cnt", 64'(bus.cycle_count), 64'd0);
    chk("r6_rst_abt", 64'(bus.aborted), 64'd0);
    chk("r6_rst_terr", 64'(bus.timeout_err), 64'd0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
